// File: rtl/trng_pkg.sv
// Shared defaults for the TRNG bit packer: word width, FIFO depth, RCT cutoff
// and the FIFO occupancy-count width helper.
package trng_pkg;

  localparam int TRNG_WORD_W     = 8;
  localparam int TRNG_FIFO_DEPTH = 4;
  localparam int TRNG_RCT_CUTOFF = 32;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
  function automatic int trng_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock FIFO; head visible combinationally, push-while-full accepted only with a pop.
// When empty, pop_dat holds the last head shown (0 after reset).
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [trng_cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = trng_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = pop_dat;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/trng_bit_packer.sv
// Packs debiased TRNG bits MSB-first into words, queues them and offers them on valid/ready.
// Optional repetition-count health test enabled by the TRNG_HEALTH_EN macro.
module trng_bit_packer
  import trng_pkg::*;
#(
  parameter int WORD_W     = TRNG_WORD_W,
  parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
  parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              bit_in,
  input  logic                              bit_valid,
  output logic [WORD_W-1:0]                 word_out,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [trng_cnt_w(FIFO_DEPTH)-1:0] fifo_count,
  output logic                              overflow,
  output logic                              health_fail
);

  localparam int BCW = $clog2(WORD_W);

  logic [WORD_W-2:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              overflow_q, overflow_d;
  logic              accept, word_done, push_req, pop, fifo_full, fifo_empty, inhibit;

  assign accept     = enable && bit_valid;
  assign word_done  = accept && (bit_cnt_q == BCW'(WORD_W - 1));
  assign push_req   = word_done && !inhibit;
  assign word_valid = !fifo_empty;
  assign pop        = word_valid && word_ready;
  assign overflow   = overflow_q;

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    overflow_d = overflow_q;
    if (accept) begin
      shreg_d   = (WORD_W-1)'({shreg_q, bit_in});
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    end
    // A completed word is lost only when there is no room and nothing leaves this edge.
    if (push_req && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          last_bit_q, last_bit_d;
  logic          health_fail_q, health_fail_d;

  always_comb begin
    run_cnt_d     = run_cnt_q;
    last_bit_d    = last_bit_q;
    health_fail_d = health_fail_q;
    if (accept) begin
      last_bit_d = bit_in;
      if (run_cnt_q != '0 && bit_in == last_bit_q) begin
        run_cnt_d = (run_cnt_q == RW'(RCT_CUTOFF)) ? run_cnt_q : run_cnt_q + 1'b1;
      end else begin
        run_cnt_d = RW'(1);
      end
      if (run_cnt_d == RW'(RCT_CUTOFF)) begin
        health_fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q     <= '0;
      last_bit_q    <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      run_cnt_q     <= run_cnt_d;
      last_bit_q    <= last_bit_d;
      health_fail_q <= health_fail_d;
    end
  end

  // The failing bit's own edge already blocks the push.
  assign inhibit     = health_fail_d;
  assign health_fail = health_fail_q;
`else
  logic unused_rct_cutoff;
  assign unused_rct_cutoff = ^RCT_CUTOFF;
  assign inhibit           = 1'b0;
  assign health_fail       = 1'b0;
`endif

  trng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_dat ({shreg_q, bit_in}),
    .pop      (pop),
    .pop_dat  (word_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_trng_bit_packer.sv
// Scenario tasks plus a randomized run against a queue-based model of the packer.
module tb_trng_bit_packer;
  import trng_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, word_ready = 1'b0;
  logic [7:0] word_out;
  logic       word_valid, overflow, health_fail;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: bits gathered into acc, completed words in a queue of at most 4.
  logic [7:0] exp_q[$];
  logic [7:0] acc, last_head;
  int         nbits, nrun;
  logic       runbit, exp_ovf, exp_hf;

  trng_bit_packer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .fifo_count(fifo_count), .overflow(overflow), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    exp_q.delete();
    acc = 8'h00; last_head = 8'h00; nbits = 0; nrun = 0;
    runbit = 1'b0; exp_ovf = 1'b0; exp_hf = 1'b0;
  endtask

  task automatic model_update(input logic en, input logic bv, input logic b, input logic rdy);
    bit was_full, popped;
    was_full = (exp_q.size() == 4);
    popped   = (exp_q.size() > 0) && rdy;
    if (popped) void'(exp_q.pop_front());
    if (en && bv) begin
      acc = {acc[6:0], b};
      nbits++;
`ifdef TRNG_HEALTH_EN
      if (nrun > 0 && b == runbit) nrun++;
      else nrun = 1;
      runbit = b;
      if (nrun >= 32) exp_hf = 1'b1;
`endif
      if (nbits == 8) begin
        nbits = 0;
        if (!exp_hf) begin
          if (was_full && !popped) exp_ovf = 1'b1;
          else exp_q.push_back(acc);
        end
      end
    end
    if (exp_q.size() > 0) last_head = exp_q[0];
  endtask

  // Drive one cycle of inputs, let the edge happen, and advance the model.
  task automatic step(input logic en, input logic bv, input logic b, input logic rdy);
    enable = en; bit_valid = bv; bit_in = b; word_ready = rdy;
    @(posedge clk);
    model_update(en, bv, b, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
    model_clear();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 7; i >= 1; i--) step(1'b1, 1'b1, w[i], 1'b0);
    step(1'b1, 1'b1, w[0], rdy_last);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (word_out !== 8'h00) begin n_bad++; $display("FAIL reset_word_out got %h want 00", word_out); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL reset_health_fail got %b want 0", health_fail); end
    do_reset();
  endtask

  task automatic test_basic_word();
    logic [7:0] w;
    w = 8'b1011_0010;
    for (int i = 7; i >= 1; i--) step(1'b1, 1'b1, w[i], 1'b0);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_before got %b want 0", word_valid); end
    step(1'b1, 1'b1, w[0], 1'b0);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 8'hB2) begin n_bad++; $display("FAIL basic_word got %h want b2", word_out); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL basic_count got %0d want 1", fifo_count); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pop_valid got %b want 0", word_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL basic_pop_count got %0d want 0", fifo_count); end
    n_cmp++; if (word_out !== 8'hB2) begin n_bad++; $display("FAIL basic_hold_word got %h want b2", word_out); end
  endtask

  task automatic test_gaps_enable();
    logic [7:0] w;
    w = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 1'b1, ~w[i], 1'b0);
      step(1'b1, 1'b0, ~w[i], 1'b0);
      step(1'b1, 1'b1, w[i], 1'b0);
    end
    n_cmp++; if (word_valid !== 1'b1 || word_out !== 8'hB2) begin n_bad++;
      $display("FAIL gaps_word got v=%b %h want v=1 b2", word_valid, word_out); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL gaps_count got %0d want 1", fifo_count); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    logic [7:0] w[5];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w[k] = 8'($urandom);
      send_word(w[k], 1'b0);
    end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (word_valid !== 1'b1 || word_out !== w[k]) begin n_bad++;
        $display("FAIL ovf_order[%0d] got v=%b %h want v=1 %h", k, word_valid, word_out, w[k]); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_cmp++; if (word_valid !== 1'b0 || overflow !== 1'b1) begin n_bad++;
      $display("FAIL ovf_drained got v=%b ovf=%b want v=0 ovf=1", word_valid, overflow); end
  endtask

  task automatic test_full_pop_same_edge();
    logic [7:0] w[5];
    do_reset();
    for (int k = 0; k < 5; k++) w[k] = 8'($urandom);
    for (int k = 0; k < 4; k++) send_word(w[k], 1'b0);
    send_word(w[4], 1'b1);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fullpop_count got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
    for (int k = 1; k < 5; k++) begin
      n_cmp++; if (word_out !== w[k]) begin n_bad++;
        $display("FAIL fullpop_order[%0d] got %h want %h", k, word_out, w[k]); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_mid_word_reset();
    logic [7:0] w;
    send_word(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (word_valid !== 1'b0 || fifo_count !== 3'd0 || word_out !== 8'h00 || overflow !== 1'b0) begin n_bad++;
      $display("FAIL midreset_outputs got v=%b c=%0d w=%h o=%b want 0", word_valid, fifo_count, word_out, overflow); end
    do_reset();
    w = 8'h3C;
    send_word(w, 1'b0);
    n_cmp++; if (word_valid !== 1'b1 || word_out !== w || fifo_count !== 3'd1) begin n_bad++;
      $display("FAIL midreset_fresh got v=%b %h c=%0d want v=1 3c c=1", word_valid, word_out, fifo_count); end
  endtask

  task automatic test_health();
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef TRNG_HEALTH_EN
    n_cmp++; if (health_fail !== 1'b1) begin n_bad++; $display("FAIL health_flag got %b want 1", health_fail); end
    n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL health_count got %0d want 3", fifo_count); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0);
    n_cmp++; if (fifo_count !== 3'd2 || health_fail !== 1'b1) begin n_bad++;
      $display("FAIL health_inhibit got c=%0d hf=%b want c=2 hf=1", fifo_count, health_fail); end
`else
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL health_flag got %b want 0", health_fail); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL health_count got %0d want 4", fifo_count); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (word_out !== 8'hFF) begin n_bad++; $display("FAIL health_word[%0d] got %h want ff", k, word_out); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
`endif
  endtask

  task automatic test_random();
    int rdy_pct;
    logic [7:0] exp_w;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_pct = $urandom_range(5, 95);
      step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 99) < rdy_pct));
      exp_w = (exp_q.size() > 0) ? exp_q[0] : last_head;
      n_cmp++; if (word_valid !== (exp_q.size() > 0)) begin n_bad++;
        $display("FAIL rand_valid c=%0d got %b want %b", c, word_valid, exp_q.size() > 0); end
      n_cmp++; if (word_out !== exp_w) begin n_bad++;
        $display("FAIL rand_word c=%0d got %h want %h", c, word_out, exp_w); end
      n_cmp++; if (fifo_count !== 3'(exp_q.size())) begin n_bad++;
        $display("FAIL rand_count c=%0d got %0d want %0d", c, fifo_count, exp_q.size()); end
      n_cmp++; if (overflow !== exp_ovf || health_fail !== exp_hf) begin n_bad++;
        $display("FAIL rand_flags c=%0d got o=%b h=%b want o=%b h=%b", c, overflow, health_fail, exp_ovf, exp_hf); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_word();
    test_gaps_enable();
    test_overflow();
    test_full_pop_same_edge();
    test_mid_word_reset();
    test_health();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
